// File: rtl/mesh_pkg.sv
// Shared definitions for the mesh terminal endpoint: destination field layout,
// broadcast encoding and the Rx drain state machine encoding.
package mesh_pkg;

    localparam int FIELD_W = 4;
    localparam logic [FIELD_W-1:0] BCAST_FIELD = 4'hF;

    // Destination fields sit just below the top byte of the packet.
    function automatic int dest_row_msb(input int pckg_sz);
        return pckg_sz - 9;
    endfunction

    function automatic int dest_col_msb(input int pckg_sz);
        return pckg_sz - 13;
    endfunction

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_WAIT  = 2'd1,
        RX_STALL = 2'd2
    } rx_state_e;

endpackage

// File: rtl/term_fifo.sv
// First-word-fall-through FIFO used for both the Tx and Rx buffers of the terminal.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module term_fifo #(
    parameter int W     = 40,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == DEPTH_CNT);
    assign count   = count_q;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

    // Storage carries no reset; dout is masked while empty instead.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/mesh_terminal_endpoint.sv
// One mesh terminal: Tx FIFO presented to the router terminal input, and an Rx side
// that drains the router output FIFO with a registered pop, checking destinations.
module mesh_terminal_endpoint
    import mesh_pkg::*;
#(
    parameter int pckg_sz    = 40,
    parameter int fifo_depth = 4,
    parameter int ROW_ID     = 1,
    parameter int COL_ID     = 1,
    parameter int CNT_W      = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tx_push,
    input  logic [pckg_sz-1:0] tx_data,
    output logic               tx_full,
    output logic [pckg_sz-1:0] data_out_i_in,
    output logic               pndng_i_in,
    input  logic               popin,
    input  logic               pndng,
    input  logic [pckg_sz-1:0] data_out,
    output logic               pop,
    output logic               rx_valid,
    output logic [pckg_sz-1:0] rx_data,
    input  logic               rx_pop,
    output logic               tx_overflow,
    output logic               misroute,
    output logic [CNT_W-1:0]   tx_count,
    output logic [CNT_W-1:0]   rx_count
);

    localparam int AW = $clog2(fifo_depth);
    localparam logic [AW:0]        DEPTH_CNT = (AW+1)'(fifo_depth);
    localparam logic [FIELD_W-1:0] MY_ROW    = FIELD_W'(ROW_ID);
    localparam logic [FIELD_W-1:0] MY_COL    = FIELD_W'(COL_ID);
    localparam int ROW_MSB = dest_row_msb(pckg_sz);
    localparam int COL_MSB = dest_col_msb(pckg_sz);

    rx_state_e        state_q, state_d;
    logic             pop_q, pop_d;
    logic             rx_push;
    logic             tx_empty;
    logic [AW:0]      tx_cnt;
    logic             rx_full;
    logic             rx_empty;
    logic [AW:0]      rx_cnt;
    logic             rx_space;
    logic             tx_pop_fire;
    logic             dest_bad;
    logic [FIELD_W-1:0] dest_row;
    logic [FIELD_W-1:0] dest_col;
    logic             tx_overflow_q;
    logic             misroute_q;
    logic [CNT_W-1:0] tx_count_q;
    logic [CNT_W-1:0] rx_count_q;

    term_fifo #(.W(pckg_sz), .DEPTH(fifo_depth)) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (tx_push),
        .din   (tx_data),
        .pop   (popin),
        .dout  (data_out_i_in),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_cnt)
    );

    term_fifo #(.W(pckg_sz), .DEPTH(fifo_depth)) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (rx_push),
        .din   (data_out),
        .pop   (rx_pop),
        .dout  (rx_data),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_cnt)
    );

    assign pndng_i_in  = !tx_empty;
    assign rx_valid    = !rx_empty;
    assign pop         = pop_q;
    assign tx_pop_fire = popin && !tx_empty;
    // A same-cycle user pop frees a slot, so a full Rx FIFO can still accept.
    assign rx_space    = (rx_cnt != DEPTH_CNT) || rx_pop;

    assign dest_row = data_out[ROW_MSB -: FIELD_W];
    assign dest_col = data_out[COL_MSB -: FIELD_W];
    assign dest_bad = ((dest_row != MY_ROW) || (dest_col != MY_COL)) &&
                      !((dest_row == BCAST_FIELD) && (dest_col == BCAST_FIELD));

    always_comb begin
        state_d = state_q;
        pop_d   = 1'b0;
        rx_push = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (pndng) begin
                    if (rx_space) begin
                        rx_push = 1'b1;
                        pop_d   = 1'b1;
                        state_d = RX_WAIT;
                    end else begin
                        state_d = RX_STALL;
                    end
                end
            end
            RX_WAIT: begin
                state_d = RX_IDLE;
            end
            RX_STALL: begin
                if (!rx_full || rx_pop) begin
                    state_d = RX_IDLE;
                end
            end
            default: begin
                state_d = RX_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= RX_IDLE;
            pop_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pop_q   <= pop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            tx_overflow_q <= 1'b0;
            misroute_q    <= 1'b0;
            tx_count_q    <= '0;
            rx_count_q    <= '0;
        end else begin
            if (tx_push && (tx_cnt == DEPTH_CNT) && !popin) begin
                tx_overflow_q <= 1'b1;
            end
            if (rx_push && dest_bad) begin
                misroute_q <= 1'b1;
            end
            if (tx_pop_fire && (tx_count_q != '1)) begin
                tx_count_q <= tx_count_q + CNT_W'(1);
            end
            if (rx_push && (rx_count_q != '1)) begin
                rx_count_q <= rx_count_q + CNT_W'(1);
            end
        end
    end

    assign tx_overflow = tx_overflow_q;
    assign misroute    = misroute_q;
    assign tx_count    = tx_count_q;
    assign rx_count    = rx_count_q;

endmodule

// File: tb/tb_mesh_terminal_endpoint.sv
// Self-checking bench for mesh_terminal_endpoint: Tx vector table plus scoreboarded
// router-side and user-side sequences.
module tb_mesh_terminal_endpoint;
    import mesh_pkg::*;

    localparam int PW = 40;

    logic          clk = 1'b0;
    logic          reset;
    logic          tx_push;
    logic [PW-1:0] tx_data;
    logic          tx_full;
    logic [PW-1:0] data_out_i_in;
    logic          pndng_i_in;
    logic          popin;
    logic          pndng;
    logic [PW-1:0] data_out;
    logic          pop;
    logic          rx_valid;
    logic [PW-1:0] rx_data;
    logic          rx_pop;
    logic          tx_overflow;
    logic          misroute;
    logic [15:0]   tx_count;
    logic [15:0]   rx_count;

    always #5 clk = ~clk;

    mesh_terminal_endpoint #(
        .pckg_sz(PW), .fifo_depth(4), .ROW_ID(1), .COL_ID(1), .CNT_W(16)
    ) dut (
        .clk(clk), .reset(reset), .tx_push(tx_push), .tx_data(tx_data),
        .tx_full(tx_full), .data_out_i_in(data_out_i_in), .pndng_i_in(pndng_i_in),
        .popin(popin), .pndng(pndng), .data_out(data_out), .pop(pop),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_pop(rx_pop),
        .tx_overflow(tx_overflow), .misroute(misroute),
        .tx_count(tx_count), .rx_count(rx_count)
    );

    int checks = 0;
    int errors = 0;
    int pop_pulses = 0;
    logic prev_pop = 1'b0;

    logic [PW-1:0] tx_exp[$];
    logic [PW-1:0] rx_exp[$];
    logic [PW-1:0] rq[$];

    typedef struct {
        logic          push;
        logic [PW-1:0] data;
        logic          popin;
        logic          e_full;
        logic          e_pndng;
        logic [PW-1:0] e_head;
        logic          e_ovf;
        logic [15:0]   e_cnt;
    } tx_vec_t;

    tx_vec_t tv[$];

    function automatic logic [PW-1:0] mk(input logic [3:0] r, input logic [3:0] c,
                                         input logic [23:0] pl);
        return {8'hC3, r, c, pl};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic p, input logic [PW-1:0] d, input logic pi,
                       input logic ef, input logic ep, input logic [PW-1:0] eh,
                       input logic eo, input logic [15:0] ec);
        tx_vec_t v;
        v.push = p; v.data = d; v.popin = pi; v.e_full = ef; v.e_pndng = ep;
        v.e_head = eh; v.e_ovf = eo; v.e_cnt = ec;
        tv.push_back(v);
    endtask

    task automatic router_refresh();
        pndng    = (rq.size() > 0);
        data_out = (rq.size() > 0) ? rq[0] : '0;
    endtask

    // One clock: scoreboard bookkeeping on pre-edge values, then advance past the edge.
    task automatic step();
        logic pb;
        logic tpop;
        pb = pop;
        if (pb === 1'b1) begin
            pop_pulses++;
            chk("pop_gap", {63'd0, prev_pop}, 64'd0);
            checks++;
            if (rq.size() == 0) begin
                errors++;
                $display("FAIL pop_no_pkt: got pop=1 required pop=0 (router empty)");
            end else begin
                rx_exp.push_back(rq.pop_front());
            end
        end
        if (rx_pop === 1'b1 && rx_valid === 1'b1) begin
            if (rx_exp.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rx_unexpected: got %0h required no packet", rx_data);
            end else begin
                chk("rx_data", 64'(rx_data), 64'(rx_exp.pop_front()));
            end
        end
        tpop = popin && (tx_exp.size() > 0);
        if (tpop) chk("tx_head", 64'(data_out_i_in), 64'(tx_exp.pop_front()));
        if (tx_push && tx_exp.size() < 4) tx_exp.push_back(tx_data);
        prev_pop = (pb === 1'b1);
        @(posedge clk);
        #1;
        router_refresh();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic drain_rx();
        rx_pop = 1'b1;
        for (int i = 0; i < 8 && rx_valid; i++) step();
        rx_pop = 1'b0;
        chk("rx_drained_valid", {63'd0, rx_valid}, 64'd0);
        chk("rx_sb_left", 64'(rx_exp.size()), 64'd0);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_pop"}, {63'd0, pop}, 64'd0);
        chk({tag, "_pndng_i_in"}, {63'd0, pndng_i_in}, 64'd0);
        chk({tag, "_rx_valid"}, {63'd0, rx_valid}, 64'd0);
        chk({tag, "_tx_full"}, {63'd0, tx_full}, 64'd0);
        chk({tag, "_tx_overflow"}, {63'd0, tx_overflow}, 64'd0);
        chk({tag, "_misroute"}, {63'd0, misroute}, 64'd0);
        chk({tag, "_tx_count"}, 64'(tx_count), 64'd0);
        chk({tag, "_rx_count"}, 64'(rx_count), 64'd0);
        chk({tag, "_data_out_i_in"}, 64'(data_out_i_in), 64'd0);
        chk({tag, "_rx_data"}, 64'(rx_data), 64'd0);
    endtask

    logic [PW-1:0] p [5];
    logic [PW-1:0] q [4];
    logic [PW-1:0] r [5];

    initial begin
        reset = 1'b0; tx_push = 1'b0; tx_data = '0; popin = 1'b0;
        rx_pop = 1'b0; pndng = 1'b0; data_out = '0;
        for (int i = 0; i < 5; i++) begin
            p[i] = mk(4'd1, 4'd1, 24'h010000 + 24'(i));
            r[i] = mk(4'd2, 4'd0, 24'h030000 + 24'(i));
        end
        for (int i = 0; i < 4; i++) q[i] = mk(4'd0, 4'd3, 24'h020000 + 24'(i));

        run(3);
        reset = 1'b1;
        tx_exp.delete(); rx_exp.delete();
        check_idle("reset");

        // Tx vectors: inputs for one cycle, then expected state after the edge.
        add(1, p[0], 0, 0, 1, p[0], 0, 0);
        add(1, p[1], 0, 0, 1, p[0], 0, 0);
        add(1, p[2], 0, 0, 1, p[0], 0, 0);
        add(1, p[3], 0, 1, 1, p[0], 0, 0);
        add(1, p[4], 0, 1, 1, p[0], 1, 0);
        add(0, '0,   1, 0, 1, p[1], 1, 1);
        add(0, '0,   1, 0, 1, p[2], 1, 2);
        add(0, '0,   1, 0, 1, p[3], 1, 3);
        add(0, '0,   1, 0, 0, '0,   1, 4);
        add(1, q[0], 1, 0, 1, q[0], 1, 4);
        add(1, q[1], 1, 0, 1, q[1], 1, 5);
        add(1, q[2], 1, 0, 1, q[2], 1, 6);
        add(1, q[3], 1, 0, 1, q[3], 1, 7);
        add(0, '0,   1, 0, 0, '0,   1, 8);
        add(1, r[0], 0, 0, 1, r[0], 1, 8);
        add(1, r[1], 0, 0, 1, r[0], 1, 8);
        add(1, r[2], 0, 0, 1, r[0], 1, 8);
        add(1, r[3], 0, 1, 1, r[0], 1, 8);
        add(1, r[4], 1, 1, 1, r[1], 1, 9);
        add(0, '0,   1, 0, 1, r[2], 1, 10);
        add(0, '0,   1, 0, 1, r[3], 1, 11);
        add(0, '0,   1, 0, 1, r[4], 1, 12);
        add(0, '0,   1, 0, 0, '0,   1, 13);

        for (int i = 0; i < tv.size(); i++) begin
            tx_push = tv[i].push; tx_data = tv[i].data; popin = tv[i].popin;
            step();
            chk($sformatf("v%0d_tx_full", i), {63'd0, tx_full}, {63'd0, tv[i].e_full});
            chk($sformatf("v%0d_pndng_i_in", i), {63'd0, pndng_i_in}, {63'd0, tv[i].e_pndng});
            chk($sformatf("v%0d_head", i), 64'(data_out_i_in), 64'(tv[i].e_head));
            chk($sformatf("v%0d_overflow", i), {63'd0, tx_overflow}, {63'd0, tv[i].e_ovf});
            chk($sformatf("v%0d_tx_count", i), 64'(tx_count), 64'(tv[i].e_cnt));
        end
        tx_push = 1'b0; popin = 1'b0; tx_data = '0;

        // Three packets for this terminal with pndng held.
        pop_pulses = 0;
        for (int i = 0; i < 3; i++) rq.push_back(mk(4'd1, 4'd1, 24'h0A0000 + 24'(i)));
        router_refresh();
        run(10);
        chk("rx3_pops", 64'(pop_pulses), 64'd3);
        chk("rx3_count", 64'(rx_count), 64'd3);
        chk("rx3_misroute", {63'd0, misroute}, 64'd0);
        drain_rx();

        // Broadcast must not flag; wrong destination flags and sticks.
        rq.push_back(mk(4'hF, 4'hF, 24'h0B0000)); router_refresh(); run(4);
        chk("bcast_misroute", {63'd0, misroute}, 64'd0);
        rq.push_back(mk(4'd2, 4'd3, 24'h0B0001)); router_refresh(); run(4);
        chk("bad_dest_misroute", {63'd0, misroute}, 64'd1);
        rq.push_back(mk(4'd1, 4'd1, 24'h0B0002)); router_refresh(); run(4);
        chk("misroute_sticky", {63'd0, misroute}, 64'd1);
        chk("rx6_count", 64'(rx_count), 64'd6);
        drain_rx();

        // Rx back-pressure: six pending, user not popping.
        pop_pulses = 0;
        for (int i = 0; i < 6; i++) rq.push_back(mk(4'd1, 4'd1, 24'h0C0000 + 24'(i)));
        router_refresh();
        run(20);
        chk("stall_pops", 64'(pop_pulses), 64'd4);
        chk("stall_state", 64'(dut.state_q), 64'(RX_STALL));
        chk("stall_rx_count", 64'(rx_count), 64'd10);
        pop_pulses = 0;
        rx_pop = 1'b1; step(); rx_pop = 1'b0;
        run(2);
        chk("unstall_pop", 64'(pop_pulses), 64'd1);
        pop_pulses = 0;
        run(4);
        chk("restall_no_pop", 64'(pop_pulses), 64'd0);

        // Load Tx, then reach RX_WAIT and reset there.
        tx_push = 1'b1; tx_data = q[0]; step();
        tx_data = q[1]; step();
        tx_push = 1'b0; tx_data = '0;
        rx_pop = 1'b1; step(); rx_pop = 1'b0;
        step();
        chk("pre_reset_state", 64'(dut.state_q), 64'(RX_WAIT));
        chk("pre_reset_pndng_i_in", {63'd0, pndng_i_in}, 64'd1);
        reset = 1'b0;
        step();
        rq.delete(); router_refresh();
        tx_exp.delete(); rx_exp.delete();
        check_idle("midreset");
        chk("midreset_state", 64'(dut.state_q), 64'(RX_IDLE));
        reset = 1'b1;
        run(2);
        chk("post_reset_pop", {63'd0, pop}, 64'd0);
        chk("post_reset_rx_valid", {63'd0, rx_valid}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mesh_terminal_endpoint.md
Name: mesh_terminal_endpoint

Overview:
RTL model of one mesh terminal, i.e. the device on the far side of a router terminal port. The Tx side holds a packet FIFO and presents data/pending to the router, which pops it. The Rx side drains the router's output FIFO through a pop handshake, checks each packet's destination against the terminal's own coordinates, and buffers it for the local user. Used to close the 4x4 mesh with synthesizable endpoints, and as a reference terminal in the mesh testbench.

Parameters:
pckg_sz, 40, packet width in bits
fifo_depth, 4, depth of each of the Tx and Rx FIFOs (power of 2, >=2)
ROW_ID, 1, this terminal's row (4-bit field)
COL_ID, 1, this terminal's column (4-bit field)
CNT_W, 16, width of the statistics counters

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
tx_push  in  1  user writes tx_data into the Tx FIFO
tx_data  in  pckg_sz  packet to send
tx_full  out  1  Tx FIFO full
data_out_i_in  out  pckg_sz  Tx FIFO head, to router terminal input
pndng_i_in  out  1  Tx FIFO not empty, to router
popin  in  1  router consumed the Tx head
pndng  in  1  router output FIFO has a packet for this terminal
data_out  in  pckg_sz  router output FIFO head
pop  out  1  pop strobe to router output FIFO
rx_valid  out  1  Rx FIFO not empty
rx_data  out  pckg_sz  Rx FIFO head
rx_pop  in  1  user consumes rx_data
tx_overflow  out  1  sticky: tx_push while full
misroute  out  1  sticky: received destination != (ROW_ID,COL_ID)
tx_count  out  CNT_W  packets accepted by router, saturating
rx_count  out  CNT_W  packets popped from router, saturating

Behaviour:
- Reset (reset==0 at posedge): both FIFOs empty; pop=0, pndng_i_in=0, rx_valid=0, tx_full=0, tx_overflow=0, misroute=0, counters=0. data_out_i_in and rx_data are 0 while their FIFO is empty. Reset mid-transfer discards all buffered packets and returns the Rx FSM to RX_IDLE.
- Packet fields: dest row = [pckg_sz-9 -: 4], dest col = [pckg_sz-13 -: 4]. All other bits pass through unchanged.
- Tx FIFO: first-word-fall-through.
  - data_out_i_in = head; pndng_i_in = !empty.
  - Push when tx_push && !full. A push into an empty FIFO makes pndng_i_in=1 on the next cycle.
  - Pop when popin && !empty; tx_count increments. popin while empty is ignored.
  - Simultaneous push and pop when full: the pop happens and the push is accepted.
  - tx_push while full with no pop: packet dropped, tx_overflow set.
- Rx FSM, three states:
  - RX_IDLE: if pndng && Rx FIFO has space (counting a same-cycle rx_pop), write data_out into the Rx FIFO, assert pop for exactly one cycle (registered), increment rx_count, compare the destination, go to RX_WAIT.
  - RX_WAIT: pop=0 for one cycle so the router's pndng/data_out can update, then go to RX_IDLE. Maximum rate is one packet every 2 cycles.
  - RX_STALL: entered from RX_IDLE when pndng=1 and the Rx FIFO is full. Stays until the FIFO has space, then goes to RX_IDLE. pop is never asserted while full.
- Destination compare: mismatch sets misroute (sticky). The packet is still stored. A broadcast destination (row and col fields all ones) never flags.
- Rx FIFO: first-word-fall-through. rx_valid = !empty; pop on rx_pop && rx_valid. rx_pop while empty is ignored.
- Counters saturate at 2^CNT_W-1; no wrap.
- Internal FIFO pointers are $clog2(fifo_depth) bits, wrapping modulo depth; occupancy is $clog2(fifo_depth)+1 bits.

Decomposition:
- Shared package mesh_pkg: field offsets (DEST_ROW_MSB, DEST_COL_MSB, FIELD_W=4), broadcast field constant, Rx FSM state enum (RX_IDLE, RX_WAIT, RX_STALL).
- One sub-module, term_fifo (FWFT, with push/pop/full/empty/count), instantiated twice.

Test Plan:
- Reset then push 3 packets with popin=0 -> pndng_i_in=1, head = first packet, tx_full=0; 5 pushes at depth 4 -> tx_full=1, 5th dropped, tx_overflow=1.
- popin held high while pushing 4 packets -> data_out_i_in presents them in order, tx_count=4, pndng_i_in falls after the last pop.
- Router presents 3 packets addressed to (1,1), pndng held -> pop pulses 1 cycle high, 1 low (3 pulses); rx_data in order; rx_count=3; misroute=0.
- Packet addressed to (2,3) -> stored, misroute=1 and stays 1; broadcast packet -> misroute unchanged.
- rx_pop=0 with 6 packets pending -> exactly 4 pops, FSM in RX_STALL; one rx_pop -> one more pop follows within 2 cycles.
- reset asserted during RX_WAIT with packets in both FIFOs -> next cycle all flags, counters and valids are 0, pop=0.
